// File: rtl/l2_memory_responder_if.sv
// Word-request bus between an L1 cache (master) and the L2 memory responder (slave).
interface l2_memory_responder_if #(
  parameter int XLEN = 32
);
  logic            req_valid;
  logic            req_write;
  logic [XLEN-1:0] l2_req_address;
  logic [XLEN-1:0] l2_word_to_store;
  logic            req_ready;
  logic            resp_valid;
  logic [XLEN-1:0] l2_fetched_word;
  logic            resp_error;

  modport master (
    output req_valid, req_write, l2_req_address, l2_word_to_store,
    input  req_ready, resp_valid, l2_fetched_word, resp_error
  );

  modport slave (
    input  req_valid, req_write, l2_req_address, l2_word_to_store,
    output req_ready, resp_valid, l2_fetched_word, resp_error
  );
endinterface

// File: rtl/l2_memory_responder.sv
// Fixed-latency single-outstanding word memory behind an L1 cache.
// One request is captured in IDLE, held for LATENCY cycles in WAIT, and
// completed with a one-cycle resp_valid pulse in RESPOND.
module l2_memory_responder #(
  parameter int XLEN      = 32,
  parameter int MEM_WORDS = 1024,
  parameter int LATENCY   = 2
) (
  input logic                 clk,
  input logic                 reset,
  l2_memory_responder_if.slave bus
);
  localparam int AW = $clog2(MEM_WORDS);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESPOND
  } state_t;

  state_t          state;
  logic [3:0]      cnt;
  logic            write_q;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] data_q;

  logic            ready_q;
  logic            resp_valid_q;
  logic            resp_error_q;
  logic [XLEN-1:0] fetched_q;

  logic [XLEN-1:0] mem [MEM_WORDS];

  logic [AW-1:0]   index;
  logic            in_range;

  // Byte address to word index; any set bit above the index field is out of range.
  assign index    = addr_q[AW+1:2];
  assign in_range = ((addr_q >> (AW + 2)) == '0);

  assign bus.req_ready       = ready_q;
  assign bus.resp_valid      = resp_valid_q;
  assign bus.resp_error      = resp_error_q;
  assign bus.l2_fetched_word = fetched_q;

  // Request FSM with registered handshake and response outputs.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      write_q      <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      ready_q      <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_error_q <= 1'b0;
      fetched_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          // req_ready is high throughout IDLE, so req_valid alone is an accept.
          if (bus.req_valid) begin
            write_q <= bus.req_write;
            addr_q  <= bus.l2_req_address;
            data_q  <= bus.l2_word_to_store;
            cnt     <= 4'(LATENCY - 1);
            ready_q <= 1'b0;
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            state        <= RESPOND;
            resp_valid_q <= 1'b1;
            resp_error_q <= ~in_range;
            fetched_q    <= (in_range && !write_q) ? mem[index] : '0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESPOND: begin
          state        <= IDLE;
          resp_valid_q <= 1'b0;
          resp_error_q <= 1'b0;
          fetched_q    <= '0;
          ready_q      <= 1'b1;
        end
        default: begin
          state        <= IDLE;
          ready_q      <= 1'b1;
          resp_valid_q <= 1'b0;
          resp_error_q <= 1'b0;
          fetched_q    <= '0;
        end
      endcase
    end
  end

  // Commit an in-range store on the edge that ends RESPOND.
  // NOTE: the storage array has no reset; its contents survive reset and are
  // undefined until written. Reset forces IDLE asynchronously, so an abandoned
  // store never reaches this write enable.
  always_ff @(posedge clk) begin
    if (state == RESPOND && write_q && in_range) begin
      mem[index] <= data_q;
    end
  end
endmodule

// File: tb/tb_l2_memory_responder.sv
// Scoreboard bench for l2_memory_responder: expected responses are queued at
// request time and compared when resp_valid appears.
module tb_l2_memory_responder;
  localparam int XLEN      = 32;
  localparam int MEM_WORDS = 1024;
  localparam int LATENCY   = 2;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   cyc   = 0;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          acc;
  } exp_t;

  exp_t sb[$];

  l2_memory_responder_if #(.XLEN(XLEN)) bus ();

  l2_memory_responder #(
    .XLEN      (XLEN),
    .MEM_WORDS (MEM_WORDS),
    .LATENCY   (LATENCY)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Response monitor: pops the scoreboard on every completion pulse.
  always @(negedge clk) begin : mon
    exp_t e;
    if (!reset) begin
      if (bus.resp_valid) begin
        if (sb.size() == 0) begin
          check("spurious_resp", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("resp_data", bus.l2_fetched_word, e.data);
          check("resp_err", {31'd0, bus.resp_error}, {31'd0, e.err});
          check("resp_latency", cyc - e.acc, LATENCY + 1);
        end
      end else begin
        check("idle_data", bus.l2_fetched_word, 32'd0);
        check("idle_err", {31'd0, bus.resp_error}, 32'd0);
      end
    end
  end

  // Issue one request, optionally scrambling inputs while it is in flight,
  // and return on the negedge of its RESPOND cycle.
  task automatic req(input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [31:0] ed, input logic ee, input bit toggle);
    int n;
    bit seen;
    exp_t e;
    @(negedge clk);
    n = 0;
    while (!bus.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", {31'd0, bus.req_ready}, 32'd1);
    bus.req_valid        = 1'b1;
    bus.req_write        = w;
    bus.l2_req_address   = a;
    bus.l2_word_to_store = d;
    e.data = ed;
    e.err  = ee;
    e.acc  = cyc;
    sb.push_back(e);
    seen = 1'b0;
    n = 0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      if (toggle) begin
        bus.req_write        = 1'($urandom_range(0, 1));
        bus.l2_req_address   = $urandom;
        bus.l2_word_to_store = $urandom;
      end else begin
        bus.req_valid = 1'b0;
      end
      check("ready_busy", {31'd0, bus.req_ready}, 32'd0);
      seen = bus.resp_valid;
    end
    bus.req_valid = 1'b0;
    check("resp_seen", {31'd0, seen}, 32'd1);
  endtask

  initial begin
    bus.req_valid        = 1'b0;
    bus.req_write        = 1'b0;
    bus.l2_req_address   = '0;
    bus.l2_word_to_store = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset_ready", {31'd0, bus.req_ready}, 32'd1);
    check("reset_valid", {31'd0, bus.resp_valid}, 32'd0);

    // Basic store then fetch.
    req(1'b1, 32'h40, 32'hDEADBEEF, 32'd0, 1'b0, 1'b0);
    req(1'b0, 32'h40, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0);

    // Known content at index 0 for the out-of-range checks.
    req(1'b1, 32'h0, 32'hA5A5A5A5, 32'd0, 1'b0, 1'b0);

    // Back-to-back line writeback and line fill.
    for (int i = 0; i < 8; i++) req(1'b1, 32'h100 + 32'(i * 4), 32'(i), 32'd0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) req(1'b0, 32'h100 + 32'(i * 4), 32'h0, 32'(i), 1'b0, 1'b0);

    // Out-of-range fetch and store must not alias index 0.
    req(1'b0, 32'h1000, 32'h0, 32'd0, 1'b1, 1'b0);
    req(1'b1, 32'h1000, 32'hFFFFFFFF, 32'd0, 1'b1, 1'b0);
    req(1'b0, 32'h0, 32'h0, 32'hA5A5A5A5, 1'b0, 1'b0);

    // Inputs scrambled during WAIT/RESPOND; the captured read must win.
    req(1'b0, 32'h40, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1);
    req(1'b0, 32'h43, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0);
    req(1'b0, 32'h0, 32'h0, 32'hA5A5A5A5, 1'b0, 1'b0);

    // Store abandoned by reset during WAIT.
    req(1'b1, 32'h80, 32'h11111111, 32'd0, 1'b0, 1'b0);
    @(negedge clk);
    check("pre_abandon_ready", {31'd0, bus.req_ready}, 32'd1);
    bus.req_valid        = 1'b1;
    bus.req_write        = 1'b1;
    bus.l2_req_address   = 32'h80;
    bus.l2_word_to_store = 32'hBAD0BAD0;
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("abandon_in_wait", {31'd0, bus.req_ready}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("post_reset_ready", {31'd0, bus.req_ready}, 32'd1);
    check("post_reset_valid", {31'd0, bus.resp_valid}, 32'd0);
    repeat (4) @(negedge clk);
    req(1'b0, 32'h80, 32'h0, 32'h11111111, 1'b0, 1'b0);
    req(1'b1, 32'h80, 32'h12345678, 32'd0, 1'b0, 1'b0);
    req(1'b0, 32'h80, 32'h0, 32'h12345678, 1'b0, 1'b0);

    repeat (5) @(negedge clk);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/l2_memory_responder.md
L2_MEMORY_RESPONDER -- requirements
Module: l2_memory_responder

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning data and address width in bits.
REQ-002 SHALL have parameter MEM_WORDS, default 1024, meaning backing storage depth in XLEN-bit words (power of two).
REQ-003 SHALL have parameter LATENCY, default 2, meaning cycles from request accept to response (legal range 1..15).
REQ-004 SHALL have port clk, input, 1, meaning sole clock; all state on rising edge.
REQ-005 SHALL have port reset, input, 1, meaning asynchronous active-high reset.
REQ-006 SHALL have port req_valid, input, 1, meaning cache presents a word request.
REQ-007 SHALL have port req_write, input, 1, meaning 1 = store word, 0 = fetch word.
REQ-008 SHALL have port l2_req_address, input, XLEN, meaning byte address of requested word.
REQ-009 SHALL have port l2_word_to_store, input, XLEN, meaning store data.
REQ-010 SHALL have port req_ready, output, 1, meaning responder can accept a request this cycle.
REQ-011 SHALL have port resp_valid, output, 1, meaning one-cycle completion pulse for the accepted request.
REQ-012 SHALL have port l2_fetched_word, output, XLEN, meaning read data, valid while resp_valid.
REQ-013 SHALL have port resp_error, output, 1, meaning accepted address was out of range, valid while resp_valid.

Function
REQ-014 SHALL implement FSM states IDLE, WAIT, RESPOND.
REQ-015 SHALL drive req_ready = 1 only in IDLE.
REQ-016 SHALL accept a request when req_valid & req_ready; capture write flag, address, store data into internal registers.
REQ-017 SHALL transition IDLE->WAIT on accept, loading latency counter with LATENCY-1.
REQ-018 SHALL decrement the counter each WAIT cycle and move WAIT->RESPOND on the cycle counter equals 0.
REQ-019 SHALL, in RESPOND, assert resp_valid for exactly one cycle, then return to IDLE unconditionally (no response back-pressure).
REQ-020 SHALL yield accept-to-resp_valid latency of exactly LATENCY+1 cycles; next accept no earlier than the cycle after resp_valid.
REQ-021 SHALL form word index from captured address bits [$clog2(MEM_WORDS)+1:2]; address bits [1:0] ignored.
REQ-022 SHALL flag out-of-range when any captured address bit above $clog2(MEM_WORDS)+1 is nonzero.
REQ-023 SHALL, for in-range write, update storage at the rising edge ending RESPOND; l2_fetched_word = 0 for writes.
REQ-024 SHALL, for in-range read, drive l2_fetched_word with storage content at index during RESPOND, reflecting all previously completed writes.
REQ-025 SHALL, for out-of-range request, assert resp_error with resp_valid, drive l2_fetched_word = 0, leave storage unchanged.
REQ-026 SHALL drive l2_fetched_word = 0 and resp_error = 0 whenever resp_valid = 0.
REQ-027 SHALL ignore req_valid and all request inputs outside IDLE; input changes in WAIT/RESPOND SHALL NOT alter the in-flight transaction.
REQ-028 SHALL support back-to-back 8-word line fills/writebacks at incrementing addresses without loss or reordering.

Reset
REQ-029 SHALL on reset assertion immediately force IDLE, counter = 0, resp_valid = 0, resp_error = 0, l2_fetched_word = 0, req_ready = 1 after release.
REQ-030 SHALL abandon an in-flight transaction on reset with no storage update and no resp_valid.
REQ-031 SHALL NOT clear storage contents on reset; contents are undefined until written.

Verification
REQ-032 SHALL verify: reset mid-run -> resp_valid=0, req_ready=1 first cycle after release.
REQ-033 SHALL verify: write 0xDEADBEEF to 0x0000_0040, then read 0x40 -> resp_valid 3 cycles after each accept (LATENCY=2), read returns 0xDEADBEEF, resp_error=0.
REQ-034 SHALL verify: 8 writes 0x100..0x11C with data = index, 8 reads in order -> returned 0..7, req_ready low during each WAIT/RESPOND.
REQ-035 SHALL verify: read 0x0000_1000 with MEM_WORDS=1024 -> resp_error=1, l2_fetched_word=0; prior contents of index 0 unchanged.
REQ-036 SHALL verify: write to 0x80 with reset asserted during WAIT, then write 0x12345678 to 0x80 and read -> 0x12345678; abandoned write absent; no spurious resp_valid.
REQ-037 SHALL verify: req_valid held high and address toggled during WAIT -> single response for originally captured address; read of 0x43 returns same word as 0x40.
